// File: rtl/brch_pkg.sv
// Shared definitions for the EX-stage branch redirect controller.
package brch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    REDIR = 2'b01,
    FLUSH = 2'b10
  } state_t;

  localparam int          MAX_FLUSH_CYCLES = 3;
  localparam logic [15:0] RESET_PC         = 16'h0000;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/brch_redirect.sv
// EX-stage redirect controller: issues fetch redirects over valid/ready,
// stalls/flushes the front end, and keeps saturating performance counts.
module brch_redirect
  import brch_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ExValid,
  input  logic             ExIsCtrl,
  input  logic             BrchOrJmpSig,
  input  logic [15:0]      ExTarget,
  input  logic             RedirectReady,
  output logic             RedirectValid,
  output logic [15:0]      RedirectPC,
  output logic             StallFront,
  output logic             FlushFD,
  output logic             FlushDX,
  output logic             Err,
  output logic [CNT_W-1:0] CtrlCount,
  output logic [CNT_W-1:0] TakenCount
);

  localparam int FW = $clog2(MAX_FLUSH_CYCLES + 1);

  state_t        state, state_next;
  logic [FW-1:0] flush_cnt;
  logic          ctrl_inc;
  logic          taken_inc;
  logic          err_set;
  logic          load_pc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    ctrl_inc   = 1'b0;
    taken_inc  = 1'b0;
    err_set    = 1'b0;
    load_pc    = 1'b0;
    unique case (state)
      IDLE: begin
        if (ExValid && ExIsCtrl) begin
          ctrl_inc = 1'b1;
          if (BrchOrJmpSig) begin
            if (!ExTarget[0]) begin
              taken_inc  = 1'b1;
              load_pc    = 1'b1;
              state_next = REDIR;
            end else begin
              err_set = 1'b1;
            end
          end
        end
      end
      REDIR: begin
        if (RedirectReady) state_next = FLUSH;
      end
      FLUSH: begin
        if (flush_cnt == FW'(1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Loaded on acceptance so FLUSH lasts exactly FLUSH_CYCLES cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flush_cnt <= '0;
    end else if (state == REDIR && RedirectReady) begin
      flush_cnt <= FW'(FLUSH_CYCLES);
    end else if (state == FLUSH) begin
      flush_cnt <= flush_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      RedirectPC <= RESET_PC;
      Err        <= 1'b0;
    end else begin
      if (load_pc) RedirectPC <= ExTarget;
      if (err_set) Err        <= 1'b1;
    end
  end

  assign RedirectValid = (state == REDIR);
  assign StallFront    = (state == REDIR);
  assign FlushFD       = (state == FLUSH);
  assign FlushDX       = (state == REDIR) || (state == FLUSH);

  sat_counter #(.W(CNT_W)) u_ctrl_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ctrl_inc),
    .count (CtrlCount)
  );

  sat_counter #(.W(CNT_W)) u_taken_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (taken_inc),
    .count (TakenCount)
  );

endmodule

// File: tb/tb_brch_redirect.sv
// Directed bench for brch_redirect: a default instance plus a narrow-counter,
// three-cycle-flush instance sharing the same stimulus.
module tb_brch_redirect;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ExValid, ExIsCtrl, BrchOrJmpSig, RedirectReady;
  logic [15:0] ExTarget;

  logic        RedirectValid, StallFront, FlushFD, FlushDX, Err;
  logic [15:0] RedirectPC, CtrlCount, TakenCount;

  logic        RedirectValid4, StallFront4, FlushFD4, FlushDX4, Err4;
  logic [15:0] RedirectPC4;
  logic [3:0]  CtrlCount4, TakenCount4;

  int tests = 0;
  int fails = 0;
  logic [15:0] exp_ctrl, exp_taken;

  always #5 clk = ~clk;

  brch_redirect #(.FLUSH_CYCLES(1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .ExValid(ExValid), .ExIsCtrl(ExIsCtrl),
    .BrchOrJmpSig(BrchOrJmpSig), .ExTarget(ExTarget), .RedirectReady(RedirectReady),
    .RedirectValid(RedirectValid), .RedirectPC(RedirectPC), .StallFront(StallFront),
    .FlushFD(FlushFD), .FlushDX(FlushDX), .Err(Err),
    .CtrlCount(CtrlCount), .TakenCount(TakenCount)
  );

  brch_redirect #(.FLUSH_CYCLES(3), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .ExValid(ExValid), .ExIsCtrl(ExIsCtrl),
    .BrchOrJmpSig(BrchOrJmpSig), .ExTarget(ExTarget), .RedirectReady(RedirectReady),
    .RedirectValid(RedirectValid4), .RedirectPC(RedirectPC4), .StallFront(StallFront4),
    .FlushFD(FlushFD4), .FlushDX(FlushDX4), .Err(Err4),
    .CtrlCount(CtrlCount4), .TakenCount(TakenCount4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_idle();
    ExValid = 1'b0; ExIsCtrl = 1'b0; BrchOrJmpSig = 1'b0; ExTarget = 16'h0000;
  endtask

  task automatic ex_branch(input logic taken, input logic [15:0] tgt);
    ExValid = 1'b1; ExIsCtrl = 1'b1; BrchOrJmpSig = taken; ExTarget = tgt;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ex_idle(); RedirectReady = 1'b0;
    step(); step();
    tests++;
    if ({RedirectValid, StallFront, FlushFD, FlushDX, Err} !== 5'b0) begin
      fails++; $display("FAIL reset_flags got %b exp 00000", {RedirectValid, StallFront, FlushFD, FlushDX, Err});
    end
    tests++;
    if (RedirectPC !== 16'h0000) begin
      fails++; $display("FAIL reset_pc got %h exp 0000", RedirectPC);
    end
    tests++;
    if (CtrlCount !== 16'd0 || TakenCount !== 16'd0) begin
      fails++; $display("FAIL reset_counts got %0d/%0d exp 0/0", CtrlCount, TakenCount);
    end
    rst_n = 1'b1;
    exp_ctrl = 16'd0; exp_taken = 16'd0;
    step();
  endtask

  task automatic test_taken_immediate();
    int n0, n4;
    ex_branch(1'b1, 16'h0040); RedirectReady = 1'b1;
    step();
    ex_idle();
    exp_ctrl++; exp_taken++;
    tests++;
    if ({RedirectValid, StallFront, FlushDX, FlushFD} !== 4'b1110) begin
      fails++; $display("FAIL imm_redir_flags got %b exp 1110", {RedirectValid, StallFront, FlushDX, FlushFD});
    end
    tests++;
    if (RedirectPC !== 16'h0040) begin
      fails++; $display("FAIL imm_redir_pc got %h exp 0040", RedirectPC);
    end
    tests++;
    if (CtrlCount !== exp_ctrl || TakenCount !== exp_taken) begin
      fails++; $display("FAIL imm_counts got %0d/%0d exp %0d/%0d", CtrlCount, TakenCount, exp_ctrl, exp_taken);
    end
    step();
    tests++;
    if ({RedirectValid, StallFront, FlushFD, FlushDX} !== 4'b0011) begin
      fails++; $display("FAIL imm_flush_flags got %b exp 0011", {RedirectValid, StallFront, FlushFD, FlushDX});
    end
    n0 = 0; n4 = 0;
    for (int i = 0; i < 6; i++) begin
      if (FlushFD) n0++;
      if (FlushFD4) n4++;
      step();
    end
    tests++;
    if (n0 != 1) begin
      fails++; $display("FAIL flush_len_1 got %0d exp 1", n0);
    end
    tests++;
    if (n4 != 3) begin
      fails++; $display("FAIL flush_len_3 got %0d exp 3", n4);
    end
    tests++;
    if ({RedirectValid, FlushDX, RedirectValid4, FlushDX4} !== 4'b0000) begin
      fails++; $display("FAIL imm_back_idle got %b exp 0000", {RedirectValid, FlushDX, RedirectValid4, FlushDX4});
    end
  endtask

  task automatic test_back_to_back();
    ex_branch(1'b1, 16'h0100); RedirectReady = 1'b1;
    step();                       // REDIR
    ExTarget = 16'h0200;
    step();                       // FLUSH, EX ignored
    step();                       // first IDLE cycle, branch presented
    step();                       // new REDIR
    ex_idle();
    exp_ctrl = exp_ctrl + 16'd2; exp_taken = exp_taken + 16'd2;
    tests++;
    if (RedirectValid !== 1'b1 || RedirectPC !== 16'h0200) begin
      fails++; $display("FAIL b2b_redir got v=%b pc=%h exp v=1 pc=0200", RedirectValid, RedirectPC);
    end
    tests++;
    if (CtrlCount !== exp_ctrl || TakenCount !== exp_taken) begin
      fails++; $display("FAIL b2b_counts got %0d/%0d exp %0d/%0d", CtrlCount, TakenCount, exp_ctrl, exp_taken);
    end
    step(); step();
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic test_backpressure();
    ex_branch(1'b1, 16'h1234); RedirectReady = 1'b0;
    step();
    exp_ctrl++; exp_taken++;
    for (int k = 0; k < 3; k++) begin
      tests++;
      if ({RedirectValid, StallFront, FlushDX, FlushFD} !== 4'b1110 || RedirectPC !== 16'h1234) begin
        fails++; $display("FAIL bp_hold%0d got %b pc=%h exp 1110 pc=1234", k, {RedirectValid, StallFront, FlushDX, FlushFD}, RedirectPC);
      end
      ExValid = k[0]; ExTarget = (k == 1) ? 16'h0003 : 16'h0055;
      step();
    end
    tests++;
    if (RedirectValid !== 1'b1 || RedirectPC !== 16'h1234) begin
      fails++; $display("FAIL bp_cycle4 got v=%b pc=%h exp v=1 pc=1234", RedirectValid, RedirectPC);
    end
    ex_branch(1'b1, 16'h0001);
    RedirectReady = 1'b1;
    step();
    ex_idle();
    tests++;
    if ({RedirectValid, FlushFD, FlushDX} !== 3'b011) begin
      fails++; $display("FAIL bp_accept got %b exp 011", {RedirectValid, FlushFD, FlushDX});
    end
    tests++;
    if (CtrlCount !== exp_ctrl || TakenCount !== exp_taken || Err !== 1'b0) begin
      fails++; $display("FAIL bp_counts got %0d/%0d err=%b exp %0d/%0d err=0", CtrlCount, TakenCount, Err, exp_ctrl, exp_taken);
    end
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic test_not_taken_misaligned();
    ex_branch(1'b0, 16'h0080);
    step();
    ex_idle();
    exp_ctrl++;
    tests++;
    if (CtrlCount !== exp_ctrl || RedirectValid !== 1'b0) begin
      fails++; $display("FAIL not_taken got cnt=%0d v=%b exp cnt=%0d v=0", CtrlCount, RedirectValid, exp_ctrl);
    end
    ExValid = 1'b1; ExIsCtrl = 1'b0; BrchOrJmpSig = 1'b1; ExTarget = 16'h0020;
    step();
    ex_idle();
    tests++;
    if (CtrlCount !== exp_ctrl || RedirectValid !== 1'b0) begin
      fails++; $display("FAIL non_ctrl got cnt=%0d v=%b exp cnt=%0d v=0", CtrlCount, RedirectValid, exp_ctrl);
    end
    ex_branch(1'b1, 16'h0041);
    step();
    ex_idle();
    exp_ctrl++;
    tests++;
    if (Err !== 1'b1 || RedirectValid !== 1'b0 || TakenCount !== exp_taken || CtrlCount !== exp_ctrl) begin
      fails++; $display("FAIL misaligned got err=%b v=%b tk=%0d ct=%0d exp err=1 v=0 tk=%0d ct=%0d", Err, RedirectValid, TakenCount, CtrlCount, exp_taken, exp_ctrl);
    end
    step(); step(); step();
    tests++;
    if (Err !== 1'b1) begin
      fails++; $display("FAIL err_sticky got %b exp 1", Err);
    end
  endtask

  task automatic test_reset_mid();
    ex_branch(1'b1, 16'h0800); RedirectReady = 1'b0;
    step();
    ex_idle();
    tests++;
    if (RedirectValid !== 1'b1) begin
      fails++; $display("FAIL mid_redir got %b exp 1", RedirectValid);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    tests++;
    if ({RedirectValid, StallFront, FlushFD, FlushDX, Err} !== 5'b0 || RedirectPC !== 16'h0000) begin
      fails++; $display("FAIL mid_reset got %b pc=%h exp 00000 pc=0000", {RedirectValid, StallFront, FlushFD, FlushDX, Err}, RedirectPC);
    end
    tests++;
    if (CtrlCount !== 16'd0 || TakenCount !== 16'd0) begin
      fails++; $display("FAIL mid_reset_counts got %0d/%0d exp 0/0", CtrlCount, TakenCount);
    end
    step();
    tests++;
    if (RedirectValid !== 1'b0) begin
      fails++; $display("FAIL mid_no_survive got %b exp 0", RedirectValid);
    end
    ex_branch(1'b1, 16'h0010); RedirectReady = 1'b1;
    step();
    ex_idle();
    tests++;
    if (RedirectValid !== 1'b1 || RedirectPC !== 16'h0010 || CtrlCount !== 16'd1 || TakenCount !== 16'd1) begin
      fails++; $display("FAIL post_reset_redir got v=%b pc=%h %0d/%0d exp v=1 pc=0010 1/1", RedirectValid, RedirectPC, CtrlCount, TakenCount);
    end
    for (int i = 0; i < 5; i++) step();
  endtask

  task automatic test_saturation();
    rst_n = 1'b0; ex_idle(); RedirectReady = 1'b0;
    step();
    rst_n = 1'b1;
    ex_branch(1'b0, 16'h0000);
    for (int i = 0; i < 15; i++) step();
    tests++;
    if (CtrlCount4 !== 4'hF) begin
      fails++; $display("FAIL sat_reach got %h exp f", CtrlCount4);
    end
    for (int i = 0; i < 5; i++) step();
    ex_idle();
    tests++;
    if (CtrlCount4 !== 4'hF || TakenCount4 !== 4'h0) begin
      fails++; $display("FAIL sat_hold got %h/%h exp f/0", CtrlCount4, TakenCount4);
    end
    tests++;
    if (CtrlCount !== 16'd20) begin
      fails++; $display("FAIL wide_count got %0d exp 20", CtrlCount);
    end
  endtask

  initial begin
    rst_n = 1'b0; RedirectReady = 1'b0;
    ex_idle();
    #1;
    test_reset();
    test_taken_immediate();
    test_back_to_back();
    test_backpressure();
    test_not_taken_misaligned();
    test_reset_mid();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/brch_redirect.md
# brch_redirect

Branch/jump redirect controller for the EX stage. Consumes the taken signal produced by the branch-condition evaluator plus the EX-stage target. Issues a PC redirect to fetch over a valid/ready handshake, freezes the front end while the redirect is pending, and flushes wrong-path instructions. Keeps saturating counts of control instructions and taken redirects for performance inspection.

## Interface
- FLUSH_CYCLES, 1, cycles of flush after redirect acceptance; legal range 1..3.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low. One clock domain only.
- ExValid  in  1  EX holds a valid instruction this cycle.
- ExIsCtrl  in  1  EX instruction is a branch/jump (BEQZ/BNEZ/BLTZ/BGEZ/JMP class).
- BrchOrJmpSig  in  1  taken indication from the condition evaluator.
- ExTarget  in  16  computed target PC.
- RedirectReady  in  1  fetch accepts the redirect.
- RedirectValid  out  1  redirect request.
- RedirectPC  out  16  redirect address.
- StallFront  out  1  freeze PC, IF/ID and ID/EX registers.
- FlushFD  out  1  squash IF/ID.
- FlushDX  out  1  squash ID/EX and kill EX side effects.
- Err  out  1  sticky misaligned-target error.
- CtrlCount  out  CNT_W  saturating count of control instructions.
- TakenCount  out  CNT_W  saturating count of issued redirects.

## Operation
- FSM states: IDLE, REDIR, FLUSH.
- IDLE, on ExValid & ExIsCtrl:
  - CtrlCount increments.
  - If BrchOrJmpSig & ~ExTarget[0]: latch ExTarget into RedirectPC, increment TakenCount, go to REDIR.
  - If BrchOrJmpSig & ExTarget[0]: set Err. No redirect. Stay in IDLE.
  - If not taken: stay in IDLE. Fetch's predict-not-taken path is correct.
- REDIR:
  - Outputs: RedirectValid=1, StallFront=1, FlushDX=1.
  - On RedirectValid & RedirectReady, load the flush counter with FLUSH_CYCLES and go to FLUSH.
- FLUSH:
  - Outputs: FlushFD=1, FlushDX=1, StallFront=0.
  - Counter decrements each cycle. At counter==1, return to IDLE.
- In REDIR and FLUSH, all EX inputs are ignored. Nothing is counted and Err cannot set.
- RedirectPC holds its value from the latch until the next taken detection.
- Counters saturate at all-ones and never wrap.
- Err clears only on reset.
- All outputs are decoded from registered state. No combinational path runs from inputs to outputs.

## Timing
- Reset values: state IDLE; RedirectValid, StallFront, FlushFD, FlushDX, Err = 0; RedirectPC = 16'h0000; CtrlCount = TakenCount = 0.
- rst_n low at any edge, including mid-REDIR or mid-FLUSH, forces the reset values at that edge. No pending redirect survives reset.
- Latency: taken detection at edge N. RedirectValid rises after edge N and is visible in cycle N+1.
- Handshake:
  - RedirectValid stays high and RedirectPC stays stable until RedirectReady is sampled high.
  - Ready may already be high in the first REDIR cycle. The transfer then completes in one cycle.
- After acceptance: exactly FLUSH_CYCLES cycles of FlushFD/FlushDX, then IDLE. A new control instruction can be accepted in the first IDLE cycle.
- Counter update and Err update are visible the cycle after the triggering edge.

## Structure
- Shared package brch_pkg holds:
  - state enum (IDLE=2'b00, REDIR=2'b01, FLUSH=2'b10);
  - constant MAX_FLUSH_CYCLES=3;
  - constant RESET_PC=16'h0000.
- One sub-module, sat_counter (parameter W; ports clk, rst_n, inc, count). It is instantiated twice, once for CtrlCount and once for TakenCount.
- Flush down-counter and FSM live in brch_redirect.

## Test plan
- Reset then idle: rst_n low 2 cycles → all outputs 0, RedirectPC=0x0000, counters 0.
- Taken with immediate ready: ExValid=ExIsCtrl=BrchOrJmpSig=1, ExTarget=0x0040, RedirectReady=1 → next cycle RedirectValid=1, RedirectPC=0x0040. Following cycle FlushFD=FlushDX=1 for FLUSH_CYCLES cycles, then IDLE. CtrlCount=1, TakenCount=1.
- Backpressure: same branch with ExTarget=0x1234 and RedirectReady low for 3 cycles → RedirectValid, StallFront and FlushDX held 3 cycles with RedirectPC=0x1234 stable. Accepted in the 4th cycle. EX inputs toggled during the wait leave the counters unchanged.
- Not-taken and misaligned: not-taken branch → CtrlCount+1, no redirect. Taken with ExTarget=0x0041 → Err=1 and stays 1, TakenCount unchanged, no RedirectValid.
- Reset mid-operation: assert rst_n low during REDIR with Ready low → next cycle IDLE, all outputs at reset values. A subsequent taken branch redirects normally.
- Saturation: CNT_W=4, 20 back-to-back not-taken control instructions → CtrlCount stops at 4'hF.
